// File: rtl/udp_frame_tx.sv
// UDP/IPv4 frame transmitter onto GMII: builds the Ethernet/IP/UDP header, streams
// payload from a synchronous-read RAM, pads, appends CRC-32 and enforces the IFG.
module udp_frame_tx #(
  parameter logic [47:0] DST_MAC    = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC    = 48'h000A3501FEC0,
  parameter logic [31:0] SRC_IP     = 32'hC0A80002,
  parameter logic [31:0] DST_IP     = 32'hC0A80003,
  parameter logic [15:0] SRC_PORT   = 16'h1F90,
  parameter logic [15:0] DST_PORT   = 16'h1F90,
  parameter logic [7:0]  TTL        = 8'h80,
  parameter int          WORD_BYTES = 4,
  parameter int          ADDR_W     = 9,
  parameter int          IFG_CYCLES = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             payload_len,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    len_err,
  output logic [ADDR_W-1:0]       ram_rd_addr,
  input  logic [8*WORD_BYTES-1:0] ram_rd_data,
  output logic                    txen,
  output logic                    txer,
  output logic [7:0]              dataout
);
  localparam int LOG_WB = $clog2(WORD_BYTES);
  localparam int OFF_W  = (LOG_WB > 0) ? LOG_WB : 1;

  typedef enum logic [2:0] {IDLE, CSUM, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IFG} state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d, len_q, len_d, ident_q, ident_d, csum_q, csum_d;
  logic [19:0]       sum_q, sum_d;
  logic [31:0]       crc_q, crc_d;
  logic              busy_q, busy_d, done_q, done_d, len_err_q, len_err_d;
  logic              txen_q, txen_d, txer_q, txer_d;
  logic [7:0]        dout_q, dout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [15:0]      total_len, udp_len, fold2;
  logic [16:0]      fold1;
  logic [335:0]     hdr;
  logic [5:0]       hidx;
  logic [OFF_W-1:0] off, pidx;
  logic [7:0]       hdr_byte, pay_byte, fcs_byte;
  logic [31:0]      fcs;

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // RAM has one cycle of read latency on top of the registered address, so the
  // address tracks the byte two positions ahead, clamped to the last real word.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [15:0] la, input logic [15:0] len);
    logic [15:0] lc;
    lc = (la >= len) ? len - 16'd1 : la;
    return ADDR_W'(lc >> LOG_WB);
  endfunction

  assign total_len = len_q + 16'd28;
  assign udp_len   = len_q + 16'd8;
  assign hdr = {DST_MAC, SRC_MAC, 16'h0800,
                16'h4500, total_len, ident_q, 16'h4000, TTL, 8'h11, csum_q, SRC_IP, DST_IP,
                SRC_PORT, DST_PORT, udp_len, 16'h0000};
  assign hidx     = 6'd41 - cnt_q[5:0];
  assign hdr_byte = hdr[{hidx, 3'b000} +: 8];
  assign off      = (WORD_BYTES == 1) ? '0 : cnt_q[OFF_W-1:0];
  assign pidx     = OFF_W'(WORD_BYTES - 1) - off;
  assign pay_byte = ram_rd_data[{pidx, 3'b000} +: 8];
  assign fcs      = ~crc_q;
  assign fcs_byte = fcs[{cnt_q[1:0], 3'b000} +: 8];
  assign fold1    = {1'b0, sum_q[15:0]} + {13'h0, sum_q[19:16]};
  assign fold2    = fold1[15:0] + {15'h0, fold1[16]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ident_d   = ident_q;
    csum_d    = csum_q;
    sum_d     = sum_q;
    crc_d     = crc_q;
    busy_d    = busy_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    len_err_d = 1'b0;
    txen_d    = 1'b0;
    txer_d    = 1'b0;
    dout_d    = 8'h00;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) begin
          if (payload_len != 16'd0 && payload_len <= 16'd1472) begin
            len_d   = payload_len;
            state_d = CSUM;
            cnt_d   = '0;
            busy_d  = 1'b1;
            crc_d   = 32'hFFFFFFFF;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      CSUM: begin
        if (cnt_q == 16'd0) begin
          sum_d = 20'h04500 + {4'h0, total_len} + {4'h0, ident_q} + 20'h04000
                + {4'h0, TTL, 8'h11} + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
                + {4'h0, DST_IP[31:16]} + {4'h0, DST_IP[15:0]};
          cnt_d = 16'd1;
        end else begin
          csum_d  = ~fold2;
          state_d = PREAMBLE;
          cnt_d   = '0;
        end
      end
      PREAMBLE: begin
        txen_d = 1'b1;
        dout_d = (cnt_q == 16'd7) ? 8'hD5 : 8'h55;
        if (cnt_q == 16'd7) begin state_d = HEADER; cnt_d = '0; end
        else cnt_d = cnt_q + 16'd1;
      end
      HEADER: begin
        txen_d = 1'b1;
        dout_d = hdr_byte;
        crc_d  = crc8(crc_q, hdr_byte);
        if (cnt_q >= 16'd40) addr_d = word_addr(cnt_q - 16'd40, len_q);
        if (cnt_q == 16'd41) begin state_d = PAYLOAD; cnt_d = '0; end
        else cnt_d = cnt_q + 16'd1;
      end
      PAYLOAD: begin
        txen_d = 1'b1;
        dout_d = pay_byte;
        crc_d  = crc8(crc_q, pay_byte);
        addr_d = word_addr(cnt_q + 16'd2, len_q);
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == len_q - 16'd1) begin
          state_d = (len_q < 16'd18) ? PAD : FCS;
          cnt_d   = '0;
        end
      end
      PAD: begin
        txen_d = 1'b1;
        crc_d  = crc8(crc_q, 8'h00);
        if (cnt_q == 16'd17 - len_q) begin state_d = FCS; cnt_d = '0; end
        else cnt_d = cnt_q + 16'd1;
      end
      FCS: begin
        txen_d = 1'b1;
        dout_d = fcs_byte;
        if (cnt_q == 16'd3) begin
          state_d = IFG;
          cnt_d   = '0;
          ident_d = ident_q + 16'd1;
        end else cnt_d = cnt_q + 16'd1;
      end
      IFG: begin
        if (cnt_q == 16'(IFG_CYCLES)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          addr_d  = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides the normal step: one errored byte, then the gap.
    if (abort && state_q inside {PREAMBLE, HEADER, PAYLOAD, PAD, FCS}) begin
      txen_d  = 1'b1;
      txer_d  = 1'b1;
      dout_d  = 8'h00;
      state_d = IFG;
      cnt_d   = '0;
      ident_d = ident_q;
      addr_d  = addr_q;
      crc_d   = crc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      ident_q   <= '0;
      csum_q    <= '0;
      sum_q     <= '0;
      crc_q     <= 32'hFFFFFFFF;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      txen_q    <= 1'b0;
      txer_q    <= 1'b0;
      dout_q    <= 8'h00;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ident_q   <= ident_d;
      csum_q    <= csum_d;
      sum_q     <= sum_d;
      crc_q     <= crc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
      txen_q    <= txen_d;
      txer_q    <= txer_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign len_err     = len_err_q;
  assign ram_rd_addr = addr_q;
  assign txen        = txen_q;
  assign txer        = txer_q;
  assign dataout     = dout_q;
endmodule

// File: doc/udp_frame_tx.md
# udp_frame_tx

Parametrised GMII-side UDP/IPv4 frame transmitter for the 1G Ethernet path. It replaces the free-running, fixed-format sender with a start/busy/done handshake and a payload width set by parameter. Frame fields come from parameters, and IP identification increments per frame. The block generates the full header checksum, pads short frames to the Ethernet minimum, computes CRC-32 internally, enforces the inter-frame gap and supports abort. It sits between the payload buffer RAM (synchronous read) and the GMII TX pins.

## Interface
- DST_MAC, 48'hFFFFFFFFFFFF, destination MAC
- SRC_MAC, 48'h000A3501FEC0, source MAC
- SRC_IP, 32'hC0A80002, source IPv4 address
- DST_IP, 32'hC0A80003, destination IPv4 address
- SRC_PORT, 16'h1F90, UDP source port
- DST_PORT, 16'h1F90, UDP destination port
- TTL, 8'h80, IP time-to-live
- WORD_BYTES, 4, payload RAM word width in bytes; legal values 1, 2, 4, 8
- ADDR_W, 9, payload RAM address width
- IFG_CYCLES, 12, idle cycles forced after each FCS
- clk  in  1  single clock; all registers update on its rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request one frame; sampled only while busy=0
- payload_len  in  16  UDP payload bytes; legal range 1..1472; latched on an accepted start
- abort  in  1  kill the current frame
- busy  out  1  frame in progress, including CSUM and IFG
- done  out  1  one-cycle pulse at end of IFG
- len_err  out  1  one-cycle pulse when start is rejected
- ram_rd_addr  out  ADDR_W  payload word address
- ram_rd_data  in  8*WORD_BYTES  payload word; valid one cycle after its address
- txen  out  1  GMII TX_EN
- txer  out  1  GMII TX_ER
- dataout  out  8  GMII TXD

## Operation
- Reset values:
  - txen, txer, busy, done, len_err = 0; dataout = 8'h00; ram_rd_addr = 0.
  - IP ident = 0; state = IDLE.
- States: IDLE, CSUM, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IFG.
- IDLE:
  - start=1 with payload_len in 1..1472: latch the length and go to CSUM; busy=1 from the next cycle.
  - start=1 with any other length: pulse len_err; stay in IDLE.
- CSUM (2 cycles): ones'-complement sum of the ten 16-bit IP header words, with the checksum field taken as 0.
  - Header words: 4500, total_len, ident, 4000, {TTL,11}, 0000, SRC_IP halves, DST_IP halves.
  - total_len = payload_len+28.
  - Fold the end-around carry twice; the checksum is the inverted 16-bit result.
- PREAMBLE: 7×55 then D5.
- HEADER: 42 bytes, in this order:
  - DST_MAC, SRC_MAC, 0800
  - 20-byte IP header
  - SRC_PORT, DST_PORT, UDP length (payload_len+8), UDP checksum 0000
- PAYLOAD: bytes from RAM, most-significant byte of each word first.
  - ram_rd_addr = 0 for the first word and increments by 1 per word.
  - Presenting the address early is the block's responsibility, so there is no stall between bytes.
  - Unused bytes of the final word are discarded.
- PAD: zero bytes while payload_len<18, bringing the frame (excluding preamble and FCS) up to 60 bytes.
- FCS: IEEE 802.3 CRC-32.
  - Polynomial 04C11DB7, init FFFFFFFF, reflected, final inversion.
  - Covers the first DST_MAC byte through the last pad byte.
  - Transmitted least-significant byte first.
- IFG: txen=0 for IFG_CYCLES cycles, then pulse done, clear busy, return to IDLE.
- IP ident increments by 1 (wrapping at 16 bits) on each frame that completes FCS; it is not incremented on aborted frames.
- abort=1 in PREAMBLE through FCS:
  - Next cycle: txen=1, txer=1, dataout=00.
  - Following cycle: txen=0; go to IFG.
  - abort in IDLE, CSUM or IFG is ignored.
- start while busy=1 is ignored. No queuing.

## Timing
- start sampled at edge E0, so the first 55 appears at E0+3. txen stays high for exactly 8+42+max(payload_len,18)+4 consecutive cycles.
- txer=0 except during the abort cycle.
- done is asserted in the same cycle busy falls. The earliest next start is accepted at that edge+1.
- reset=1 on any edge: all outputs take reset values on that edge. A frame in flight is truncated with no txer and no done.
- Simultaneous start and reset: reset wins.

## Test plan
- payload_len=4, WORD_BYTES=4, RAM word0=DEADBEEF → 72 txen cycles:
  - Preamble, then FF×6, 00 0A 35 01 FE C0, 08 00, 45 00 00 20.
  - Payload DE AD BE EF, 14 zero pad bytes.
  - CRC-32 residue over frame+FCS = C704DD7B; ident=0000.
- Two back-to-back frames → second IP ident=0001; gap of txen=0 ≥ IFG_CYCLES; second frame's IP checksum recomputed correctly, verified by summing the header to FFFF.
- payload_len=1472, WORD_BYTES=8 → 1526 continuous txen cycles with no gaps; ram_rd_addr reaches 183; UDP length 05C8; total_len 05DC.
- payload_len=0 and payload_len=1473 → len_err pulse, busy stays 0, txen stays 0.
- abort asserted at the 20th payload byte → one cycle of txen=1/txer=1, then txen=0; done after IFG; next frame's ident unchanged.
- reset asserted mid-payload → next edge: txen=0, busy=0, ram_rd_addr=0; a subsequent frame carries ident=0000.
